pipelined_adder: RTL and testbench

// - Parametrised, pipelined add/subtract unit; successor to the combinational ripple adder.
// - Splits a BITSIZE-wide operation into STAGES chunks. Each chunk is a ripple add.
// - Carry is registered between chunks, giving one chunk per cycle.
// - Valid/ready on both sides; sits between operand issue and the ALU result mux.
//

---
 rtl/pipelined_adder.sv | 148 ++++++++++++++
 tb/tb_pipelined_adder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder -- parametrised, pipelined add/subtract unit.
//
// A BITSIZE-wide add (A+B+carry_i) or subtract (A-B) is split into STAGES
// chunks of CHUNK = BITSIZE/STAGES bits. Each stage ripple-adds one chunk and
// registers the chunk carry for the next stage, so one chunk is resolved per
// cycle. Operands still waiting for their chunk are skewed forward alongside
// the partial result. All stages advance in lock-step when the output side can
// take a new value (no bubble compression).
//
// Optional feature: define PIPELINED_ADDER_SAT_EN to clamp the result to the
// signed range on overflow (clamp direction follows the sign of A). Without
// it the result wraps modulo 2^BITSIZE.
//
// Ports:
//   clk          clock, rising edge
//   rstn_i       asynchronous active-low reset
//   flush_i      synchronous drop of every in-flight operation
//   valid_i      operands valid          ready_o     operands accepted this cycle
//   A_i, B_i     operands                sub_i       1: A-B, 0: A+B+carry_i
//   carry_i      carry-in for add (ignored on subtract)
//   valid_o      result valid            ready_i     consumer takes result
//   R_o          result                  carry_o     unsigned carry-out (sub: 1 = no borrow)
//   overflow_o   signed overflow
module pipelined_adder #(
  parameter int BITSIZE = 64,
  parameter int STAGES  = 4
) (
  input  logic               clk,
  input  logic               rstn_i,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [BITSIZE-1:0] A_i,
  input  logic [BITSIZE-1:0] B_i,
  input  logic               sub_i,
  input  logic               carry_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [BITSIZE-1:0] R_o,
  output logic               carry_o,
  output logic               overflow_o
);

  localparam int CHUNK = BITSIZE / STAGES;
  localparam int MSB   = BITSIZE - 1;
  // Intermediate register count; kept at least 1 so STAGES=1 still elaborates.
  localparam int MID   = (STAGES > 1) ? STAGES - 1 : 1;

  // Per-stage state: original A, effective B (already inverted for subtract),
  // partial result (lower chunks filled in), and carry into the next chunk.
  typedef struct packed {
    logic [BITSIZE-1:0] a;
    logic [BITSIZE-1:0] b;
    logic [BITSIZE-1:0] r;
    logic               c;
  } stage_t;

  // Ripple-add chunk k of a and b with the incoming carry.
  function automatic stage_t add_chunk(input stage_t s, input int k);
    stage_t         o;
    logic [CHUNK:0] sum;
    o   = s;
    sum = {1'b0, s.a[k*CHUNK +: CHUNK]} + {1'b0, s.b[k*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, s.c};
    o.r[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    o.c = sum[CHUNK];
    return o;
  endfunction

`ifdef PIPELINED_ADDER_SAT_EN
  // Clamp towards the sign of A: same-sign add or opposite-sign subtract can
  // only overflow away from A's sign.
  function automatic logic [BITSIZE-1:0] saturate(input logic [BITSIZE-1:0] r,
                                                  input logic              ovf,
                                                  input logic              a_sign);
    if (!ovf)   return r;
    if (a_sign) return {1'b1, {(BITSIZE-1){1'b0}}};
    return {1'b0, {(BITSIZE-1){1'b1}}};
  endfunction
`endif

  logic   adv;
  stage_t st_in  [STAGES];
  stage_t st_out [STAGES];
  logic   vld_in [STAGES];
  stage_t st_p   [MID];
  logic   vld_p  [MID];

  assign adv     = ~valid_o | ready_i;
  assign ready_o = adv;

  // Stage 0 input: subtract is A + ~B + 1.
  assign st_in[0]  = {A_i, (sub_i ? ~B_i : B_i), {BITSIZE{1'b0}}, (sub_i | carry_i)};
  assign vld_in[0] = valid_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    assign st_out[k] = add_chunk(st_in[k], k);
  end

  // ---- stage k -> stage k+1 boundary ----
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_stage
    always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i)      vld_p[k] <= 1'b0;
      else if (flush_i) vld_p[k] <= 1'b0;
      else if (adv)     vld_p[k] <= vld_in[k];
    end

    always_ff @(posedge clk) begin
      if (adv) st_p[k] <= st_out[k];
    end

    assign st_in[k+1]  = st_p[k];
    assign vld_in[k+1] = vld_p[k];
  end

  logic               msb_cin;
  logic               ovf;
  logic [BITSIZE-1:0] res;

  // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ cin.
  assign msb_cin = st_out[STAGES-1].a[MSB] ^ st_out[STAGES-1].b[MSB] ^ st_out[STAGES-1].r[MSB];
  assign ovf     = msb_cin ^ st_out[STAGES-1].c;

`ifdef PIPELINED_ADDER_SAT_EN
  assign res = saturate(st_out[STAGES-1].r, ovf, st_out[STAGES-1].a[MSB]);
`else
  assign res = st_out[STAGES-1].r;
`endif

  // ---- final stage -> output register boundary ----
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o    <= 1'b0;
      R_o        <= '0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (flush_i)  valid_o <= 1'b0;
      else if (adv) valid_o <= vld_in[STAGES-1];
      if (adv) begin
        R_o        <= res;
        carry_o    <= st_out[STAGES-1].c;
        overflow_o <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (BITSIZE=16, STAGES=4, plus a
// STAGES=1 instance). Expected results come from a plain-arithmetic model
// held in a queue in acceptance order.
module tb_pipelined_adder;

  localparam int W  = 16;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         rstn_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] A_i = '0;
  logic [W-1:0] B_i = '0;
  logic         sub_i = 1'b0;
  logic         carry_i = 1'b0;
  logic         valid_o;
  logic         ready_i = 1'b1;
  logic [W-1:0] R_o;
  logic         carry_o;
  logic         overflow_o;

  logic         s1_flush_i = 1'b0;
  logic         s1_valid_i = 1'b0;
  logic         s1_ready_o;
  logic [W-1:0] s1_A_i = '0;
  logic [W-1:0] s1_B_i = '0;
  logic         s1_sub_i = 1'b0;
  logic         s1_carry_i = 1'b0;
  logic         s1_valid_o;
  logic         s1_ready_i = 1'b1;
  logic [W-1:0] s1_R_o;
  logic         s1_carry_o;
  logic         s1_overflow_o;

  int errors = 0;
  int checks = 0;
  int seen   = 0;
  logic [W+1:0] exp_q [$];

  always #5 clk = ~clk;

  pipelined_adder #(.BITSIZE(W), .STAGES(ST)) u_dut (
    .clk(clk), .rstn_i(rstn_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .A_i(A_i), .B_i(B_i), .sub_i(sub_i), .carry_i(carry_i),
    .valid_o(valid_o), .ready_i(ready_i), .R_o(R_o), .carry_o(carry_o),
    .overflow_o(overflow_o)
  );

  pipelined_adder #(.BITSIZE(W), .STAGES(1)) u_dut1 (
    .clk(clk), .rstn_i(rstn_i), .flush_i(s1_flush_i), .valid_i(s1_valid_i),
    .ready_o(s1_ready_o), .A_i(s1_A_i), .B_i(s1_B_i), .sub_i(s1_sub_i),
    .carry_i(s1_carry_i), .valid_o(s1_valid_o), .ready_i(s1_ready_i),
    .R_o(s1_R_o), .carry_o(s1_carry_o), .overflow_o(s1_overflow_o)
  );

  // Returns {result, carry, overflow} from integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic ci);
    int ua, ub, us, sa, sb, sr;
    logic [W-1:0] r;
    logic c, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      us = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      us = ua + ub + int'(ci);
      c  = (us > 65535);
      sr = sa + sb + int'(ci);
    end
    r  = us[W-1:0];
    ov = (sr > 32767) || (sr < -32768);
`ifdef PIPELINED_ADDER_SAT_EN
    if (ov) r = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    return {r, c, ov};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  // One clock: verify outputs against the scoreboard before the edge, then
  // update the scoreboard with what the edge did.
  task automatic cycle();
    logic acc, emit, fl;
    #1;
    acc  = valid_i & ready_o & ~flush_i;
    emit = valid_o & ready_i;
    fl   = flush_i;
    if (valid_o) begin
      check("no_spurious_valid", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("result", 32'({R_o, carry_o, overflow_o}), 32'(exp_q[0]));
    end
    @(posedge clk);
    if (emit) seen++;
    if (emit && exp_q.size() > 0) void'(exp_q.pop_front());
    if (fl) exp_q.delete();
    if (acc) exp_q.push_back(model(A_i, B_i, sub_i, carry_i));
    #1;
  endtask

  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic ci);
    A_i = a; B_i = b; sub_i = s; carry_i = ci;
  endtask

  // Called right after the accept cycle; counts cycles until valid_o.
  task automatic latency(input string tag);
    int n;
    n = 1;
    while (!valid_o && n < 20) begin
      cycle();
      n++;
    end
    check(tag, 32'(n), 32'(ST));
  endtask

  initial begin
    int idx, cyc, s0;
    logic acc;
    logic [W-1:0] sat_sub, sat_s1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_R_o", 32'(R_o), 32'd0);
    check("rst_flags", 32'({carry_o, overflow_o}), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd1);
    check("rst_s1_valid_o", 32'(s1_valid_o), 32'd0);
    @(negedge clk);
    rstn_i = 1'b1;
    @(posedge clk);
    #1;

    // 0xFFFF + 0x0001
    set_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    valid_i = 1'b1; ready_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    latency("t1_latency");
    check("t1_R", 32'(R_o), 32'h0000);
    check("t1_carry", 32'(carry_o), 32'd1);
    check("t1_ovf", 32'(overflow_o), 32'd0);
    repeat (2) cycle();

    // 0x8000 - 0x0001
`ifdef PIPELINED_ADDER_SAT_EN
    sat_sub = 16'h8000;
`else
    sat_sub = 16'h7FFF;
`endif
    set_op(16'h8000, 16'h0001, 1'b1, 1'b0);
    valid_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    latency("t2_latency");
    check("t2_R", 32'(R_o), 32'(sat_sub));
    check("t2_carry", 32'(carry_o), 32'd1);
    check("t2_ovf", 32'(overflow_o), 32'd1);
    repeat (2) cycle();

    // 8 back-to-back ops with a 3-cycle output stall
    idx = 0; cyc = 0; s0 = seen;
    while ((idx < 8 || exp_q.size() > 0 || valid_o) && cyc < 60) begin
      valid_i = (idx < 8);
      set_op(16'(idx), 16'(16'h0100 * idx), 1'b0, 1'b0);
      ready_i = !(cyc >= 5 && cyc < 8);
      #1;
      if (!ready_i && valid_o) check("t3_stall_ready", 32'(ready_o), 32'd0);
      acc = valid_i & ready_o;
      cycle();
      if (acc) idx++;
      cyc++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    check("t3_count", 32'(seen - s0), 32'd8);

    // Async reset with 3 ops in flight
    for (int i = 0; i < 3; i++) begin
      set_op(16'(16'h1111 * (i + 1)), 16'h0F0F, 1'b0, 1'b1);
      valid_i = 1'b1;
      cycle();
    end
    valid_i = 1'b0;
    cycle();
    cycle();
    rstn_i = 1'b0;
    #1;
    check("t4_valid_o_async", 32'(valid_o), 32'd0);
    check("t4_R_o_async", 32'(R_o), 32'd0);
    check("t4_ready_o", 32'(ready_o), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rstn_i = 1'b1;
    s0 = seen;
    repeat (6) cycle();
    check("t4_nothing_after_reset", 32'(seen - s0), 32'd0);
    set_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    valid_i = 1'b1;
    cycle();
    valid_i = 1'b0;
    latency("t4_latency");
    check("t4_R", 32'(R_o), 32'h5555);
    repeat (2) cycle();

    // Flush while stalled with an op presented
    ready_i = 1'b0;
    valid_i = 1'b1;
    set_op(16'h00AA, 16'h0055, 1'b0, 1'b0);
    cyc = 0;
    while (!valid_o && cyc < 20) begin
      cycle();
      cyc++;
    end
    check("t5_filled", 32'(valid_o), 32'd1);
    flush_i = 1'b1;
    set_op(16'hBEEF, 16'h0001, 1'b0, 1'b0);
    cycle();
    flush_i = 1'b0; valid_i = 1'b0;
    check("t5_valid_o_cleared", 32'(valid_o), 32'd0);
    check("t5_ready_o", 32'(ready_o), 32'd1);
    ready_i = 1'b1;
    s0 = seen;
    repeat (6) cycle();
    check("t5_flush_drop", 32'(seen - s0), 32'd0);
    // Flush beats a simultaneous accept
    flush_i = 1'b1; valid_i = 1'b1;
    set_op(16'h0101, 16'h0202, 1'b0, 1'b0);
    cycle();
    flush_i = 1'b0; valid_i = 1'b0;
    s0 = seen;
    repeat (6) cycle();
    check("t5_flush_priority", 32'(seen - s0), 32'd0);

    // Randomized traffic with boundary operands and occasional flush
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a, b;
      case ($urandom_range(0, 5))
        0: a = 16'h7FFF;
        1: a = 16'h8000;
        2: a = 16'hFFFF;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: b = 16'h0001;
        1: b = 16'h8000;
        2: b = 16'h0000;
        default: b = 16'($urandom);
      endcase
      set_op(a, b, 1'($urandom), 1'($urandom));
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 39) == 0);
      cycle();
    end
    valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    cyc = 0;
    while ((exp_q.size() > 0 || valid_o) && cyc < 30) begin
      cycle();
      cyc++;
    end
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    // STAGES=1 instance: 0x7FFF + 0x0001
`ifdef PIPELINED_ADDER_SAT_EN
    sat_s1 = 16'h7FFF;
`else
    sat_s1 = 16'h8000;
`endif
    s1_A_i = 16'h7FFF; s1_B_i = 16'h0001; s1_sub_i = 1'b0; s1_carry_i = 1'b0;
    s1_valid_i = 1'b1;
    #1;
    check("t6_ready", 32'(s1_ready_o), 32'd1);
    @(posedge clk);
    #1;
    s1_valid_i = 1'b0;
    check("t6_latency1", 32'(s1_valid_o), 32'd1);
    check("t6_R", 32'(s1_R_o), 32'(sat_s1));
    check("t6_ovf", 32'(s1_overflow_o), 32'd1);
    check("t6_carry", 32'(s1_carry_o), 32'd0);
    check("t6_model", 32'({s1_R_o, s1_carry_o, s1_overflow_o}),
          32'(model(16'h7FFF, 16'h0001, 1'b0, 1'b0)));
    @(posedge clk);
    #1;
    check("t6_single", 32'(s1_valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
